isdu_lite: RTL and testbench
============================

ISDU_LITE -- requirements
Module: isdu_lite

Interface
REQ-001 Parameter: MEM_WAIT, default 3, number of cycles Mem_OE is held per instruction read (legal 1..7).
REQ-002 Clk  in  1  system clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Run  in  1  level; starts execution from HALTED.
REQ-005 Continue  in  1  level; releases PAUSE.
REQ-006 Opcode  in  4  IR[15:12], valid from the cycle after LD_IR.
REQ-007 IR_5  in  1  IR[5], immediate select for ADD/AND.
REQ-008 BEN  in  1  registered branch-enable from the NZP/BEN stage.
REQ-009 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  out  1 each  register load strobes.
REQ-010 GatePC, GateMDR, GateALU  out  1 each  bus drivers.
REQ-011 PCMUX  out  2  00=PC+1, 01=bus, 10=PC+offset adder.
REQ-012 ALUK  out  2  00=ADD, 01=AND, 10=NOT, 11=PASSA.
REQ-013 SR2MUX  out  1  copies IR_5 in ADD/AND states, else 0.
REQ-014 Mem_OE  out  1  memory read enable.

Function
REQ-015 All outputs SHALL be Moore, decoded from the state register (and the IR_5 input for SR2MUX only); default value 0 in every state.
REQ-016 States: HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12, PAUSE1, PAUSE2.
REQ-017 HALTED: all outputs 0; Run=1 -> S18, else remain.
REQ-018 S18: GatePC, LD_MAR, LD_PC, PCMUX=00 -> S33.
REQ-019 S33: Mem_OE=1 for exactly MEM_WAIT cycles via internal down-counter loaded on entry; LD_MDR=1 on the last of them only -> S35.
REQ-020 S35: GateMDR, LD_IR -> S32.
REQ-021 S32: LD_BEN=1; dispatch on Opcode: 0001->S01, 0101->S05, 1001->S09, 0000->S00, 1100->S12, 1101->PAUSE1, any other -> S18.
REQ-022 S01/S05/S09: GateALU, LD_REG, LD_CC, ALUK=00/01/10 respectively -> S18.
REQ-023 S00: no strobes; sample BEN (loaded at end of S32, valid this cycle): BEN=1 -> S22, BEN=0 -> S18.
REQ-024 S22: LD_PC, PCMUX=10 -> S18.
REQ-025 S12: GateALU, ALUK=11, LD_PC, PCMUX=01 -> S18.
REQ-026 PAUSE1: hold until Continue=1 -> PAUSE2; PAUSE2: hold until Continue=0 -> S18 (one instruction per Continue pulse).
REQ-027 At most one Gate* SHALL be high in any cycle; LD_CC and LD_BEN SHALL never be high in the same cycle.
REQ-028 Run is ignored outside HALTED; Run deassertion mid-instruction SHALL NOT alter sequencing.
REQ-029 Instruction latency: ALU ops and JMP MEM_WAIT+4 cycles; taken BR MEM_WAIT+5; not-taken BR MEM_WAIT+4.

Reset
REQ-030 Reset=1 SHALL immediately (asynchronously) force state HALTED, wait counter 0, all outputs 0, including mid-S33 or mid-PAUSE.
REQ-031 After reset release, no transition SHALL occur until first rising edge with Run=1.

Structure
REQ-032 State enum, opcode constants, PCMUX and ALUK encodings SHALL live in shared package isdu_pkg.
REQ-033 Single module; the memory wait counter is an internal register of width clog2(MEM_WAIT+1), no sub-module.

Verification
REQ-034 Reset mid-S33 (MEM_WAIT=3, assert at 2nd wait cycle) -> all outputs 0 same cycle, state HALTED, LD_MDR never pulsed.
REQ-035 Run=1, Opcode=0001, IR_5=1 -> S18,S33x3,S35,S32,S01; in S01 GateALU=LD_REG=LD_CC=SR2MUX=1, ALUK=00; back to S18 at cycle 8.
REQ-036 Opcode=0000, BEN=1 at S00 -> S22 with LD_PC=1, PCMUX=10; repeat with BEN=0 -> S18 directly, LD_PC never high after S18.
REQ-037 Opcode=1101: stays PAUSE1 with Continue=0 for 10 cycles; Continue 1 -> PAUSE2; held 1 stays; 0 -> S18.
REQ-038 Opcode=1111 (unsupported) -> S32 to S18, no LD_REG/LD_CC/LD_PC in that transition.
REQ-039 Every cycle of all runs: assert at most one Gate*, never LD_CC&LD_BEN, Mem_OE high exactly MEM_WAIT consecutive cycles per fetch.

Source files
------------

// File: rtl/isdu_pkg.sv
// Shared encodings for the ISDU-lite control FSM: state enum, dispatched opcodes,
// PC mux and ALU function selects.
package isdu_pkg;

  typedef enum logic [3:0] {
    ST_HALTED = 4'd0,
    ST_S18    = 4'd1,
    ST_S33    = 4'd2,
    ST_S35    = 4'd3,
    ST_S32    = 4'd4,
    ST_S01    = 4'd5,
    ST_S05    = 4'd6,
    ST_S09    = 4'd7,
    ST_S00    = 4'd8,
    ST_S22    = 4'd9,
    ST_S12    = 4'd10,
    ST_PAUSE1 = 4'd11,
    ST_PAUSE2 = 4'd12
  } state_e;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage

// File: rtl/isdu_lite.sv
// ISDU-lite: Moore control FSM sequencing fetch / decode / execute for a small
// LC-3-style datapath, with a parameterised memory wait and a Continue handshake pause.
module isdu_lite
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic [1:0] PCMUX,
  output logic [1:0] ALUK,
  output logic       SR2MUX,
  output logic       Mem_OE
);

  localparam int CW = $clog2(MEM_WAIT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_last;

  assign wait_last = (cnt_q <= CW'(1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_HALTED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HALTED: if (Run) state_d = ST_S18;
      ST_S18: begin
        state_d = ST_S33;
        cnt_d   = CW'(MEM_WAIT);
      end
      ST_S33: begin
        if (wait_last) begin
          state_d = ST_S35;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_S35: state_d = ST_S32;
      ST_S32: begin
        case (Opcode)
          OP_ADD:   state_d = ST_S01;
          OP_AND:   state_d = ST_S05;
          OP_NOT:   state_d = ST_S09;
          OP_BR:    state_d = ST_S00;
          OP_JMP:   state_d = ST_S12;
          OP_PAUSE: state_d = ST_PAUSE1;
          default:  state_d = ST_S18;
        endcase
      end
      ST_S00:    state_d = BEN ? ST_S22 : ST_S18;
      ST_S01, ST_S05, ST_S09, ST_S22, ST_S12: state_d = ST_S18;
      ST_PAUSE1: if (Continue) state_d = ST_PAUSE2;
      ST_PAUSE2: if (!Continue) state_d = ST_S18;
      default:   state_d = ST_HALTED;
    endcase
  end

  // Outputs decode from registered state only; SR2MUX additionally follows IR_5.
  always_comb begin
    LD_MAR  = 1'b0;
    LD_MDR  = 1'b0;
    LD_IR   = 1'b0;
    LD_BEN  = 1'b0;
    LD_CC   = 1'b0;
    LD_REG  = 1'b0;
    LD_PC   = 1'b0;
    GatePC  = 1'b0;
    GateMDR = 1'b0;
    GateALU = 1'b0;
    PCMUX   = PCMUX_INC;
    ALUK    = ALUK_ADD;
    SR2MUX  = 1'b0;
    Mem_OE  = 1'b0;
    case (state_q)
      ST_S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = PCMUX_INC;
      end
      ST_S33: begin
        Mem_OE = 1'b1;
        LD_MDR = wait_last;
      end
      ST_S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      ST_S32: LD_BEN = 1'b1;
      ST_S01, ST_S05, ST_S09: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        ALUK    = (state_q == ST_S01) ? ALUK_ADD :
                  (state_q == ST_S05) ? ALUK_AND : ALUK_NOT;
        SR2MUX  = (state_q != ST_S09) ? IR_5 : 1'b0;
      end
      ST_S22: begin
        LD_PC = 1'b1;
        PCMUX = PCMUX_ADDER;
      end
      ST_S12: begin
        GateALU = 1'b1;
        ALUK    = ALUK_PASSA;
        LD_PC   = 1'b1;
        PCMUX   = PCMUX_BUS;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_lite.sv
// Randomised instruction stream against a per-instruction expected output trace.
module tb_isdu_lite;
  import isdu_pkg::*;

  localparam int W = 3;

  localparam int V_MAR = 15, V_MDR = 14, V_IR = 13, V_BEN = 12, V_CC = 11, V_REG = 10;
  localparam int V_PC = 9, V_GPC = 8, V_GMDR = 7, V_GALU = 6, V_SR2 = 1, V_OE = 0;

  logic Clk = 1'b0;
  logic Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic GatePC, GateMDR, GateALU, SR2MUX, Mem_OE;
  logic [1:0] PCMUX, ALUK;

  always #5 Clk = ~Clk;

  isdu_lite #(.MEM_WAIT(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .PCMUX(PCMUX),
    .ALUK(ALUK), .SR2MUX(SR2MUX), .Mem_OE(Mem_OE)
  );

  wire [15:0] obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                     GatePC, GateMDR, GateALU, PCMUX, ALUK, SR2MUX, Mem_OE};

  typedef struct {
    logic [15:0] exp;
    logic        sr2_en;
    logic        run;
    logic        cont;
    logic [3:0]  op;
    logic        ben;
  } cyc_t;

  cyc_t       q[$];
  logic [3:0] cur_op = 4'b0000;
  int         n_chk = 0, n_fail = 0, oe_run = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] b(input int i);
    logic [15:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] pcm(input logic [1:0] m);
    return {10'b0, m, 4'b0};
  endfunction

  function automatic logic [15:0] aluk(input logic [1:0] k);
    return {12'b0, k, 2'b0};
  endfunction

  task automatic push(input logic [15:0] v, input logic sr2, input logic c, input logic [3:0] op,
                      input logic ben_v);
    cyc_t e;
    e.exp = v; e.sr2_en = sr2; e.run = 1'($urandom); e.cont = c; e.op = op; e.ben = ben_v;
    q.push_back(e);
  endtask

  // Expected cycle-by-cycle outputs of one whole instruction, fetch through execute.
  task automatic add_instr(input logic [3:0] op, input logic ben_v, input int n1, input int n2);
    push(b(V_MAR) | b(V_PC) | b(V_GPC) | pcm(PCMUX_INC), 1'b0, 1'($urandom), cur_op, 1'($urandom));
    for (int i = 0; i < W; i++)
      push(b(V_OE) | ((i == W - 1) ? b(V_MDR) : 16'h0), 1'b0, 1'($urandom), cur_op, 1'($urandom));
    push(b(V_GMDR) | b(V_IR), 1'b0, 1'($urandom), cur_op, 1'($urandom));
    cur_op = op;
    push(b(V_BEN), 1'b0, 1'($urandom), op, ~ben_v);
    case (op)
      4'b0001: push(b(V_GALU) | b(V_REG) | b(V_CC) | aluk(ALUK_ADD), 1'b1, 1'($urandom), op, 1'($urandom));
      4'b0101: push(b(V_GALU) | b(V_REG) | b(V_CC) | aluk(ALUK_AND), 1'b1, 1'($urandom), op, 1'($urandom));
      4'b1001: push(b(V_GALU) | b(V_REG) | b(V_CC) | aluk(ALUK_NOT), 1'b0, 1'($urandom), op, 1'($urandom));
      4'b0000: begin
        push(16'h0, 1'b0, 1'($urandom), op, ben_v);
        if (ben_v) push(b(V_PC) | pcm(PCMUX_ADDER), 1'b0, 1'($urandom), op, 1'($urandom));
      end
      4'b1100: push(b(V_GALU) | aluk(ALUK_PASSA) | b(V_PC) | pcm(PCMUX_BUS), 1'b0, 1'($urandom), op,
                    1'($urandom));
      4'b1101: begin
        for (int i = 0; i < n1; i++) push(16'h0, 1'b0, 1'b0, op, 1'($urandom));
        push(16'h0, 1'b0, 1'b1, op, 1'($urandom));
        for (int i = 0; i < n2; i++) push(16'h0, 1'b0, 1'b1, op, 1'($urandom));
        push(16'h0, 1'b0, 1'b0, op, 1'($urandom));
      end
      default: ;
    endcase
  endtask

  task automatic invariants();
    chk("gate_onehot", {15'b0, ($countones({GatePC, GateMDR, GateALU}) <= 1)}, 16'h1);
    chk("cc_ben_excl", {15'b0, LD_CC & LD_BEN}, 16'h0);
    if (Mem_OE) oe_run++;
    else if (oe_run != 0) begin
      chk("oe_len", 16'(oe_run), 16'(W));
      oe_run = 0;
    end
  endtask

  task automatic run_cycle(input cyc_t e, input string tag);
    logic [15:0] exp;
    @(negedge Clk);
    Run = e.run; Continue = e.cont; Opcode = e.op; BEN = e.ben; IR_5 = 1'($urandom);
    #1;
    exp = e.exp;
    if (e.sr2_en && IR_5) exp[V_SR2] = 1'b1;
    chk(tag, obs, exp);
    invariants();
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) run_cycle(q.pop_front(), tag);
  endtask

  task automatic halted_cycle(input logic run_v, input string tag);
    cyc_t e;
    e.exp = 16'h0; e.sr2_en = 1'b0; e.run = run_v; e.cont = 1'($urandom);
    e.op = 4'($urandom); e.ben = 1'($urandom);
    run_cycle(e, tag);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0000; IR_5 = 1'b0; BEN = 1'b0;
    @(negedge Clk); @(negedge Clk); #1;
    chk("reset_outs", obs, 16'h0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) halted_cycle(1'b0, "halted_idle");
    halted_cycle(1'b1, "halted_run");

    add_instr(4'b0001, 1'b0, 0, 0); drain("add");
    add_instr(4'b0000, 1'b1, 0, 0); drain("br_taken");
    add_instr(4'b0000, 1'b0, 0, 0); drain("br_not_taken");
    add_instr(4'b1101, 1'b0, 10, 3); drain("pause");
    add_instr(4'b1111, 1'b0, 0, 0); drain("unsupported");
    add_instr(4'b1100, 1'b0, 0, 0); drain("jmp");
    add_instr(4'b0101, 1'b0, 0, 0); drain("and");
    add_instr(4'b1001, 1'b0, 0, 0); drain("not");
    for (int i = 0; i < 60; i++) begin
      add_instr(4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      drain("random");
    end

    // Reset asserted between edges on the second memory-wait cycle of a fetch.
    add_instr(4'b0001, 1'b0, 0, 0);
    run_cycle(q.pop_front(), "rst_fetch_s18");
    run_cycle(q.pop_front(), "rst_fetch_w1");
    run_cycle(q.pop_front(), "rst_fetch_w2");
    q.delete();
    #2 Reset = 1'b1;
    #1 chk("reset_async", obs, 16'h0);
    oe_run = 0;
    @(negedge Clk); #1;
    chk("reset_held", obs, 16'h0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) halted_cycle(1'b0, "post_reset_idle");
    halted_cycle(1'b1, "post_reset_run");
    cur_op = 4'b0000;
    add_instr(4'b0001, 1'b0, 0, 0); drain("post_reset_add");
    add_instr(4'b0000, 1'b1, 0, 0); drain("post_reset_br");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
